boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 nreset  input  1  reset, synchronous, active-low.
REQ-004 rx  input  1  UART serial input, 8N1, idle high, asynchronous to clk.
REQ-005 cpu_data  input  32  CPU write data.
REQ-006 cpu_address  input  16  CPU RAM address.
REQ-007 cpu_wren  input  1  CPU RAM write enable.
REQ-008 ram_data  output  32  RAM write data.
REQ-009 ram_address  output  16  RAM address.
REQ-010 ram_wren  output  1  RAM write enable.
REQ-011 cpu_nreset  output  1  CPU reset, active-low, registered.
REQ-012 status  output  8  loader state code.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Receiver: falling edge on synchronized rx SHALL start a frame; start bit re-checked low at CLKS_PER_BIT/2; data bits sampled at bit centres, LSB first; stop bit sampled at its centre.
REQ-015 Start bit high at mid-sample SHALL be treated as a glitch: return to idle, no byte, no error.
REQ-016 Stop bit low SHALL be a framing error -> state ERROR.
REQ-017 Load protocol: 2 bytes word count N (MSB first), then N words of 4 bytes each, MSB first.
REQ-018 FSM states and status codes: LEN_HI 0x10, LEN_LO 0x11, WORD 0x20, WRITE 0x21, RELEASE 0x30, RUN 0x40, ERROR 0xE0.
REQ-019 LEN_HI -> LEN_LO on byte received; LEN_LO -> WORD on byte received if N!=0, else -> RELEASE.
REQ-020 WORD: bytes shifted into a 32-bit assembly register; 4th byte -> WRITE.
REQ-021 WRITE SHALL last exactly one cycle: ram_wren=1, ram_address=word index, ram_data=assembled word; index increments on exit.
REQ-022 WRITE exit: -> WORD if index+1 < N, else -> RELEASE.
REQ-023 Word index 16 bits, starts at 0; N=0xFFFF writes addresses 0..0xFFFE; no wrap occurs.
REQ-024 A byte completing during WRITE SHALL NOT be lost: the receiver holds it until WORD consumes it (the stop-bit half-period exceeds one cycle).
REQ-025 RELEASE SHALL last 2 cycles: ram_address=0, ram_wren=0, cpu_nreset=0; then -> RUN.
REQ-026 RUN: cpu_nreset=1; for the first 2 cycles ram_address=0 and ram_wren=0 are forced; thereafter ram_data/ram_address/ram_wren = cpu_data/cpu_address/cpu_wren combinationally.
REQ-027 RUN and ERROR SHALL be terminal until nreset; rx activity in RUN is ignored.
REQ-028 In every state except RUN, ram_wren SHALL be 0 outside WRITE and the CPU inputs SHALL have no effect.
REQ-029 cpu_nreset SHALL be 0 in all states except RUN.
REQ-030 ERROR: cpu_nreset=0, ram_wren=0, status=0xE0.

Reset
REQ-031 nreset=0 sampled on a rising edge SHALL force state LEN_HI, receiver idle, index 0, N 0, assembly register 0, ram_wren 0, ram_address 0, ram_data 0, cpu_nreset 0, status 0x10.
REQ-032 nreset asserted mid-frame or mid-load SHALL abort the load; no RAM write occurs on that edge or after it until a new frame completes.
REQ-033 Synchronizer flops SHALL reset to 1 (idle).

Verification (CLKS_PER_BIT=4)
REQ-034 Send 00 02 DE AD BE EF 01 02 03 04 -> ram_wren pulses twice: addr 0 data 0xDEADBEEF, addr 1 data 0x01020304; RELEASE 2 cycles; then cpu_nreset=1, status 0x40.
REQ-035 Send 00 00 -> no write; RELEASE then RUN; ram_address=0 for the first 2 RUN cycles, then follows cpu_address=0x1234 with cpu_wren=1.
REQ-036 Byte 0x55 with stop bit driven low -> status 0xE0, cpu_nreset stays 0 for 1000 cycles despite further valid bytes.
REQ-037 rx low pulse of 1 cycle -> no byte received, status remains 0x10.
REQ-038 Pull nreset low after 2 of 4 word bytes, release, resend 00 01 AA BB CC DD -> single write addr 0 data 0xAABBCCDD.
REQ-039 Back-to-back bytes with no idle gap across a WRITE -> all words written in order, none dropped.

Source files
------------

// File: rtl/boot_loader.sv
// UART boot loader: receives a word count and image over 8N1 serial, writes it into RAM,
// then releases the CPU from reset and hands it the RAM port.
module boot_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        rx,
    input  logic [31:0] cpu_data,
    input  logic [15:0] cpu_address,
    input  logic        cpu_wren,
    output logic [31:0] ram_data,
    output logic [15:0] ram_address,
    output logic        ram_wren,
    output logic        cpu_nreset,
    output logic [7:0]  status
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE, S_RELEASE, S_RUN, S_ERROR} state_t;

    logic [1:0]  sync_reg;
    logic        rx_s;
    rx_state_t   rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic        rx_prev_reg;
    logic [7:0]  rx_byte_reg;
    logic        rx_valid_reg;
    logic        rx_done, rx_err, consume;

    state_t      state_reg, state_next;
    logic [15:0] count_reg, count_next;
    logic [15:0] index_reg, index_next;
    logic [31:0] word_reg, word_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [1:0]  hold_cnt_reg, hold_cnt_next;
    logic        cpu_nreset_reg;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync_reg     <= 2'b11;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_byte_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], rx};
            rx_prev_reg  <= rx_s;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            // A finished byte is held until the loader FSM takes it (it may be busy in WRITE)
            if (rx_done) begin
                rx_byte_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (consume) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + 16'd1;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done       = 1'b0;
        rx_err        = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev_reg && !rx_s) rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_s, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
                end
            end
            default: begin
                // Return to idle at the stop-bit centre so a back-to-back start edge is seen
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_IDLE;
                    rx_done       = rx_s;
                    rx_err        = !rx_s;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg      <= S_LEN_HI;
            count_reg      <= '0;
            index_reg      <= '0;
            word_reg       <= '0;
            byte_cnt_reg   <= '0;
            hold_cnt_reg   <= '0;
            cpu_nreset_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            index_reg      <= index_next;
            word_reg       <= word_next;
            byte_cnt_reg   <= byte_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
            cpu_nreset_reg <= (state_next == S_RUN);
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        index_next    = index_reg;
        word_next     = word_reg;
        byte_cnt_next = byte_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        consume       = 1'b0;
        case (state_reg)
            S_LEN_HI: begin
                if (rx_valid_reg) begin
                    consume    = 1'b1;
                    count_next = {rx_byte_reg, 8'h00};
                    state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid_reg) begin
                    consume       = 1'b1;
                    count_next    = {count_reg[15:8], rx_byte_reg};
                    index_next    = '0;
                    byte_cnt_next = '0;
                    hold_cnt_next = '0;
                    state_next    = ({count_reg[15:8], rx_byte_reg} == 16'h0000) ? S_RELEASE : S_WORD;
                end
            end
            S_WORD: begin
                if (rx_valid_reg) begin
                    consume       = 1'b1;
                    word_next     = {word_reg[23:0], rx_byte_reg};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                index_next = index_reg + 16'd1;
                // Widened compare so N = 0xFFFF stops after address 0xFFFE without wrapping
                if (({1'b0, index_reg} + 17'd1) < {1'b0, count_reg}) begin
                    state_next = S_WORD;
                end else begin
                    hold_cnt_next = '0;
                    state_next    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                hold_cnt_next = hold_cnt_reg + 2'd1;
                if (hold_cnt_reg == 2'd1) begin
                    hold_cnt_next = '0;
                    state_next    = S_RUN;
                end
            end
            S_RUN: begin
                if (hold_cnt_reg != 2'd2) hold_cnt_next = hold_cnt_reg + 2'd1;
            end
            default: ;
        endcase
        if (rx_err && state_reg != S_RUN && state_reg != S_ERROR) state_next = S_ERROR;
    end

    always_comb begin
        ram_data    = '0;
        ram_address = '0;
        ram_wren    = 1'b0;
        status      = 8'hE0;
        case (state_reg)
            S_LEN_HI:  status = 8'h10;
            S_LEN_LO:  status = 8'h11;
            S_WORD:    status = 8'h20;
            S_WRITE: begin
                status      = 8'h21;
                ram_data    = word_reg;
                ram_address = index_reg;
                // Reset on this edge must suppress the write the RAM would otherwise take
                ram_wren    = nreset;
            end
            S_RELEASE: status = 8'h30;
            S_RUN: begin
                status = 8'h40;
                if (hold_cnt_reg == 2'd2) begin
                    ram_data    = cpu_data;
                    ram_address = cpu_address;
                    ram_wren    = cpu_wren;
                end
            end
            default:   status = 8'hE0;
        endcase
    end

    assign cpu_nreset = cpu_nreset_reg;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader at CLKS_PER_BIT=4: loads, empty load, framing error,
// glitch rejection, mid-load reset and back-to-back bytes.
module tb_boot_loader;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] cpu_data = '0;
    logic [15:0] cpu_address = '0;
    logic        cpu_wren = 1'b0;
    logic [31:0] ram_data;
    logic [15:0] ram_address;
    logic        ram_wren;
    logic        cpu_nreset;
    logic [7:0]  status;

    int vectors = 0;
    int miscompares = 0;

    // Write log and RELEASE-cycle counter, only ever incremented by the monitor
    logic [15:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int wr_count = 0;
    int rel_cycles = 0;
    int wr_base, rel_base;
    logic [7:0] tx_q [$];

    boot_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .nreset(nreset), .rx(rx),
        .cpu_data(cpu_data), .cpu_address(cpu_address), .cpu_wren(cpu_wren),
        .ram_data(ram_data), .ram_address(ram_address), .ram_wren(ram_wren),
        .cpu_nreset(cpu_nreset), .status(status)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_wren && !cpu_nreset) begin
            if (wr_count < 64) begin
                wr_addr[wr_count] = ram_address;
                wr_data[wr_count] = ram_data;
            end
            wr_count = wr_count + 1;
        end
        if (status == 8'h30) rel_cycles = rel_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        wr_base = wr_count;
        rel_base = rel_cycles;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_q(input int gap);
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], 1'b1);
            repeat (gap) @(negedge clk);
        end
    endtask

    // Leaves the caller at the negedge of the first RUN cycle
    task automatic wait_run(input string tag);
        int n = 0;
        while (status != 8'h40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(status == 8'h40), 32'd1);
    endtask

    initial begin
        // Reset state, sampled while nreset is still low
        repeat (3) @(negedge clk);
        chk("rst_status", 32'(status), 32'h10);
        chk("rst_cpu_nreset", 32'(cpu_nreset), 32'd0);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_data", ram_data, 32'd0);

        // Two-word load; CPU inputs active throughout must have no effect
        do_reset();
        cpu_wren = 1'b1; cpu_address = 16'h5555; cpu_data = 32'h12345678;
        tx_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        send_q(3);
        wait_run("t34_run");
        chk("t34_nwr", 32'(wr_count - wr_base), 32'd2);
        chk("t34_a0", 32'(wr_addr[wr_base]), 32'd0);
        chk("t34_d0", wr_data[wr_base], 32'hDEADBEEF);
        chk("t34_a1", 32'(wr_addr[wr_base + 1]), 32'd1);
        chk("t34_d1", wr_data[wr_base + 1], 32'h01020304);
        chk("t34_release", 32'(rel_cycles - rel_base), 32'd2);
        chk("t34_cpu_nreset", 32'(cpu_nreset), 32'd1);
        chk("t34_run_wren0", 32'(ram_wren), 32'd0);
        cpu_wren = 1'b0;

        // Empty load, then CPU takes the RAM port after two forced cycles
        do_reset();
        cpu_address = 16'h1234; cpu_wren = 1'b1; cpu_data = 32'hCAFEF00D;
        tx_q = '{8'h00, 8'h00};
        send_q(2);
        wait_run("t35_run");
        chk("t35_nwr", 32'(wr_count - wr_base), 32'd0);
        chk("t35_release", 32'(rel_cycles - rel_base), 32'd2);
        chk("t35_c0_addr", 32'(ram_address), 32'd0);
        chk("t35_c0_wren", 32'(ram_wren), 32'd0);
        @(negedge clk);
        chk("t35_c1_addr", 32'(ram_address), 32'd0);
        chk("t35_c1_wren", 32'(ram_wren), 32'd0);
        @(negedge clk);
        chk("t35_c2_addr", 32'(ram_address), 32'h1234);
        chk("t35_c2_wren", 32'(ram_wren), 32'd1);
        chk("t35_c2_data", ram_data, 32'hCAFEF00D);
        // rx activity in RUN is ignored
        send_byte(8'h55, 1'b0);
        chk("t35_run_hold", 32'(status), 32'h40);
        cpu_wren = 1'b0;

        // Framing error is terminal
        do_reset();
        send_byte(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        chk("t36_status", 32'(status), 32'hE0);
        tx_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send_q(2);
        begin
            int high_cycles = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (cpu_nreset) high_cycles++;
            end
            chk("t36_cpu_held", 32'(high_cycles), 32'd0);
        end
        chk("t36_status_end", 32'(status), 32'hE0);
        chk("t36_nwr", 32'(wr_count - wr_base), 32'd0);

        // One-cycle glitch yields no byte; a following length byte pair lands in WORD
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        chk("t37_status", 32'(status), 32'h10);
        tx_q = '{8'h00, 8'h01};
        send_q(3);
        chk("t37_after", 32'(status), 32'h20);

        // Reset mid-load aborts; the reload writes a single word
        do_reset();
        tx_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send_q(2);
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        chk("t38_status_rst", 32'(status), 32'h10);
        repeat (2) @(negedge clk);
        tx_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_q(2);
        wait_run("t38_run");
        chk("t38_nwr", 32'(wr_count - wr_base), 32'd1);
        chk("t38_a0", 32'(wr_addr[wr_base]), 32'd0);
        chk("t38_d0", wr_data[wr_base], 32'hAABBCCDD);

        // Back-to-back bytes with no idle gap across WRITE cycles
        do_reset();
        tx_q = '{8'h00, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h10, 8'h20, 8'h30, 8'h40,
                 8'hFF, 8'hEE, 8'h00, 8'h01};
        send_q(0);
        wait_run("t39_run");
        chk("t39_nwr", 32'(wr_count - wr_base), 32'd3);
        chk("t39_a0", 32'(wr_addr[wr_base]), 32'd0);
        chk("t39_d0", wr_data[wr_base], 32'h0A0B0C0D);
        chk("t39_a1", 32'(wr_addr[wr_base + 1]), 32'd1);
        chk("t39_d1", wr_data[wr_base + 1], 32'h10203040);
        chk("t39_a2", 32'(wr_addr[wr_base + 2]), 32'd2);
        chk("t39_d2", wr_data[wr_base + 2], 32'hFFEE0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
